// File: rtl/pulse_sched_pkg.sv
// Shared state encoding and default widths for the pulse burst scheduler.
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DIV_W   = 24;
  localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/pulse_div_core.sv
// Divider + toggle flop + falling-edge counter. Generates one burst of square
// pulses while enabled; start clears the datapath ready for a new burst.
module pulse_div_core
  import pulse_sched_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic [DIV_W-1:0] hp,
  input  logic [CNT_W-1:0] count,
  output logic             pulse,
  output logic             finished
);

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] edges;
  logic             at_toggle;

  assign at_toggle = en && (div == hp);
  // The burst ends on the falling toggle that completes the requested pulse count.
  assign finished  = at_toggle && pulse && ((edges + CNT_W'(1)) == count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div   <= '0;
      pulse <= 1'b0;
      edges <= '0;
    end else if (start) begin
      div   <= '0;
      pulse <= 1'b0;
      edges <= '0;
    end else if (en) begin
      if (at_toggle) begin
        div   <= '0;
        pulse <= ~pulse;
        if (pulse) begin
          edges <= edges + CNT_W'(1);
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/pulse_burst_scheduler.sv
// Round-robin sharing of one pulse generator among NUM_REQ requesters.
// Optional macro PULSE_ABORT_EN: granted requester dropping req ends the burst early.
module pulse_burst_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DIV_W   = DEF_DIV_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DIV_W-1:0] half_period,
  input  logic [NUM_REQ*CNT_W-1:0] pulse_count,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     pulse_out,
  output logic [NUM_REQ-1:0]       done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t     state, state_nx;
  logic [IDX_W-1:0] idx, rr_ptr, hit_idx, scan_idx;
  logic             hit, start, core_pulse, core_finished;
  logic [DIV_W-1:0] hp_lat;
  logic [CNT_W-1:0] cnt_lat;
  logic [NUM_REQ-1:0] owner;
  int               scan;

  logic [DIV_W-1:0] hp_arr  [NUM_REQ];
  logic [CNT_W-1:0] cnt_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign hp_arr[g]  = half_period[g*DIV_W +: DIV_W];
    assign cnt_arr[g] = pulse_count[g*CNT_W +: CNT_W];
  end

  // Scan from the farthest candidate back toward rr_ptr so the closest one wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    scan     = 0;
    scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NUM_REQ) begin
        scan = scan - NUM_REQ;
      end
      scan_idx = IDX_W'(scan);
      if (req[scan_idx]) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          start    = 1'b1;
          state_nx = (cnt_arr[hit_idx] == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (core_finished) begin
          state_nx = DONE;
        end
`ifdef PULSE_ABORT_EN
        if (!req[idx]) begin
          state_nx = DONE;
        end
`endif
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      rr_ptr  <= '0;
      hp_lat  <= '0;
      cnt_lat <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        idx     <= hit_idx;
        hp_lat  <= hp_arr[hit_idx];
        cnt_lat <= cnt_arr[hit_idx];
      end
      if (state == DONE) begin
        rr_ptr <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  pulse_div_core #(
    .DIV_W(DIV_W),
    .CNT_W(CNT_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .en      (state == RUN),
    .hp      (hp_lat),
    .count   (cnt_lat),
    .pulse   (core_pulse),
    .finished(core_finished)
  );

  // Gating by RUN also forces the pin low on an aborted burst.
  assign owner     = NUM_REQ'(1) << idx;
  assign busy      = (state != IDLE);
  assign grant     = busy ? owner : '0;
  assign done      = (state == DONE) ? owner : '0;
  assign pulse_out = core_pulse & (state == RUN);

endmodule
